line_rasterizer: RTL and testbench
==================================

Name: line_rasterizer

Overview:
- Bresenham line-drawing engine upstream of FIFO_top, alongside brush.
- Accepts a line command (two endpoints plus colour).
- Emits one pixel write per cycle into the FIFO on the same push/full handshake brush uses: writecounter_x, writecounter_y, writergb, fifopush.
- Write-side arbitration between brush and this block is handled outside this block.

Parameters:
- HPOS_WIDTH, 10, width of x coordinates.
- VPOS_WIDTH, 10, width of y coordinates.
- RESOLUTION_H, 640, visible width; used for clipping.
- RESOLUTION_V, 480, visible height; used for clipping.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  command strobe; sampled only in IDLE.
- x0  in  HPOS_WIDTH  start x (unsigned).
- y0  in  VPOS_WIDTH  start y (unsigned).
- x1  in  HPOS_WIDTH  end x.
- y1  in  VPOS_WIDTH  end y.
- color  in  3  RGB colour of the line.
- fifofull  in  1  FIFO full flag.
- fifopush  out  1  write strobe to FIFO.
- writecounter_x  out  HPOS_WIDTH  pixel x to write.
- writecounter_y  out  VPOS_WIDTH  pixel y to write.
- writergb  out  3  pixel colour.
- busy  out  1  high from the cycle after start is accepted until done.
- done  out  1  one-cycle pulse after the last pixel is pushed.

Behaviour:
- One clock (clk); reset is synchronous, active-high.
- Reset: state=IDLE; fifopush=0, writecounter_x=0, writecounter_y=0, writergb=0, busy=0, done=0.
- Reset mid-line aborts immediately; no further push after the reset cycle.
- FSM states:
  - IDLE: start=1 latches x0, y0, x1, y1, color → SETUP.
  - SETUP (1 cycle): compute the fields below, load cur=(x0,y0) → PLOT.
    - dx=|x1-x0|, dy=-|y1-y0|.
    - sx=+1 if x0<x1 else -1; sy=+1 if y0<y1 else -1.
    - err=dx+dy.
  - PLOT: see push handshake and stepping rules below.
  - DONE (1 cycle): done=1, busy=0 → IDLE.
- Push handshake (PLOT):
  - fifopush = (state==PLOT) && !fifofull. Combinational from registered state; the coordinate outputs are registers holding cur.
  - A pixel is transferred only in a cycle where fifopush=1.
  - If fifofull=1: hold cur and err, no push, no step (stall). No pixel is ever dropped or duplicated.
- Stepping (on each transfer):
  - If cur==(x1,y1) → DONE.
  - Else e2=2*err:
    - if e2>=dy: err+=dy, x+=sx.
    - if e2<=dx: err+=dx, y+=sy.
    - Both adjustments use the same e2.
- Arithmetic:
  - err and e2 are signed, width max(HPOS_WIDTH,VPOS_WIDTH)+2.
  - dx and dy are signed, width max+1.
  - Coordinate arithmetic never wraps, because the line stays within the endpoint bounding box.
- Pixel count = max(dx,|dy|)+1; a degenerate line (x0==x1, y0==y1) pushes exactly one pixel.
- Latency: start accepted at cycle N → SETUP at N+1 → first push possible at N+2. With no stalls, the last push is at N+1+count and done is at N+2+count.
- Throughput: 1 pixel/cycle when fifofull=0.
- writergb = latched color for the whole line.
- start while busy: ignored; not queued.
- start asserted in the same cycle as done: ignored. It is accepted on the next IDLE cycle.
- Back-to-back commands: the earliest start accept is the cycle after DONE.

Optional Feature:
- Macro: LINE_RASTERIZER_CLIP_EN.
- Defined: pixels with x>=RESOLUTION_H or y>=RESOLUTION_V are stepped over without asserting fifopush. Each such pixel takes 1 cycle and ignores fifofull.
- Not defined: every pixel is pushed regardless of position; the downstream framebuffer handles range.
- Endpoint termination and the done timing rule (done one cycle after the last step) are identical in both builds.

Test Plan:
- Horizontal line: x0=10, y0=5, x1=14, y1=5, color=3'b100, fifofull=0 → 5 pushes at x=10..14, y=5, consecutive cycles; done 1 cycle after the last push.
- Steep reverse diagonal: (20,20)→(17,13) → 8 pushes; y decreases by 1 each step; x decrements exactly 3 times; last pixel = (17,13).
- Backpressure: line (0,0)→(7,0) with fifofull held high for 3 cycles after the 2nd push → no pushes during the stall; exactly 8 pushes total, in order, with no duplicates.
- Degenerate line and ignored start: (5,5)→(5,5) → exactly 1 push. A second start pulse while busy → ignored; only one done pulse.
- Reset mid-line: assert reset after the 3rd push of (0,0)→(99,0) → fifopush=0, busy=0, all outputs 0 in the next cycle. A following start draws a fresh line correctly.
- Clip build (LINE_RASTERIZER_CLIP_EN): line (636,0)→(643,0) → 4 pushes (x=636..639); done 8 cycles after the first plot cycle. Without the macro → 8 pushes.

Source files
------------

// File: rtl/line_rasterizer.sv
// line_rasterizer: Bresenham line engine feeding the pixel FIFO.
// Takes a line command, then produces one pixel per transfer cycle on the
// fifopush/fifofull handshake.
// Optional build macro: LINE_RASTERIZER_CLIP_EN. When it is defined, pixels
// that fall outside RESOLUTION_H x RESOLUTION_V are stepped over without a push.
module line_rasterizer #(
    parameter int HPOS_WIDTH   = 10,
    parameter int VPOS_WIDTH   = 10,
    parameter int RESOLUTION_H = 640,
    parameter int RESOLUTION_V = 480
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [HPOS_WIDTH-1:0] x0,
    input  logic [VPOS_WIDTH-1:0] y0,
    input  logic [HPOS_WIDTH-1:0] x1,
    input  logic [VPOS_WIDTH-1:0] y1,
    input  logic [2:0]            color,
    input  logic                  fifofull,
    output logic                  fifopush,
    output logic [HPOS_WIDTH-1:0] writecounter_x,
    output logic [VPOS_WIDTH-1:0] writecounter_y,
    output logic [2:0]            writergb,
    output logic                  busy,
    output logic                  done
);

    localparam int W = (HPOS_WIDTH > VPOS_WIDTH) ? HPOS_WIDTH : VPOS_WIDTH;

    typedef enum logic [1:0] {S_IDLE, S_SETUP, S_PLOT, S_DONE} state_t;

    state_t state_reg, state_next;

    logic [HPOS_WIDTH-1:0] x0_reg, x1_reg, cur_x_reg;
    logic [VPOS_WIDTH-1:0] y0_reg, y1_reg, cur_y_reg;
    logic [2:0]            color_reg;
    logic signed [W:0]     dx_reg, dy_reg;
    logic signed [W+1:0]   err_reg;
    logic                  sx_neg_reg, sy_neg_reg;

    // Datapath helper signals
    logic                  offscreen;
    logic                  advance;
    logic                  at_end;
    logic signed [W+1:0]   e2, dx_ext, dy_ext, err_next;
    logic                  step_x, step_y;
    logic [W-1:0]          xa, xb, ya, yb, adx, ady;
    logic signed [W:0]     dx_setup, dy_setup;
    logic signed [W+1:0]   err_setup;

`ifdef LINE_RASTERIZER_CLIP_EN
    localparam logic [HPOS_WIDTH:0] RES_H_W = (HPOS_WIDTH+1)'(RESOLUTION_H);
    localparam logic [VPOS_WIDTH:0] RES_V_W = (VPOS_WIDTH+1)'(RESOLUTION_V);
    assign offscreen = ({1'b0, cur_x_reg} >= RES_H_W) || ({1'b0, cur_y_reg} >= RES_V_W);
`else
    assign offscreen = 1'b0;
`endif

    // Setup-time arithmetic: magnitudes of the deltas and the initial error term
    always_comb begin
        xa        = W'(x0_reg);
        xb        = W'(x1_reg);
        ya        = W'(y0_reg);
        yb        = W'(y1_reg);
        adx       = (xb >= xa) ? (xb - xa) : (xa - xb);
        ady       = (yb >= ya) ? (yb - ya) : (ya - yb);
        dx_setup  = $signed({1'b0, adx});
        dy_setup  = -$signed({1'b0, ady});
        err_setup = $signed({dx_setup[W], dx_setup}) + $signed({dy_setup[W], dy_setup});
    end

    // Per-pixel Bresenham decision; both tests share the same e2
    always_comb begin
        at_end   = (cur_x_reg == x1_reg) && (cur_y_reg == y1_reg);
        e2       = err_reg <<< 1;
        dx_ext   = $signed({dx_reg[W], dx_reg});
        dy_ext   = $signed({dy_reg[W], dy_reg});
        step_x   = (e2 >= dy_ext);
        step_y   = (e2 <= dx_ext);
        err_next = err_reg + (step_x ? dy_ext : '0) + (step_y ? dx_ext : '0);
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) state_reg <= S_IDLE;
        else       state_reg <= state_next;
    end

    // Next-state and handshake decode; an off-screen pixel advances without a push
    always_comb begin
        state_next = state_reg;
        fifopush   = 1'b0;
        advance    = 1'b0;
        case (state_reg)
            S_IDLE:  if (start) state_next = S_SETUP;
            S_SETUP: state_next = S_PLOT;
            S_PLOT: begin
                advance  = offscreen || !fifofull;
                fifopush = !offscreen && !fifofull;
                if (advance && at_end) state_next = S_DONE;
            end
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // Command latch, setup load and cursor stepping
    always_ff @(posedge clk) begin
        if (reset) begin
            x0_reg     <= '0;
            y0_reg     <= '0;
            x1_reg     <= '0;
            y1_reg     <= '0;
            color_reg  <= '0;
            cur_x_reg  <= '0;
            cur_y_reg  <= '0;
            dx_reg     <= '0;
            dy_reg     <= '0;
            err_reg    <= '0;
            sx_neg_reg <= 1'b0;
            sy_neg_reg <= 1'b0;
        end else begin
            case (state_reg)
                S_IDLE: begin
                    if (start) begin
                        x0_reg    <= x0;
                        y0_reg    <= y0;
                        x1_reg    <= x1;
                        y1_reg    <= y1;
                        color_reg <= color;
                    end
                end
                S_SETUP: begin
                    cur_x_reg  <= x0_reg;
                    cur_y_reg  <= y0_reg;
                    dx_reg     <= dx_setup;
                    dy_reg     <= dy_setup;
                    err_reg    <= err_setup;
                    sx_neg_reg <= !(x0_reg < x1_reg);
                    sy_neg_reg <= !(y0_reg < y1_reg);
                end
                S_PLOT: begin
                    if (advance && !at_end) begin
                        err_reg <= err_next;
                        if (step_x)
                            cur_x_reg <= sx_neg_reg ? cur_x_reg - HPOS_WIDTH'(1)
                                                    : cur_x_reg + HPOS_WIDTH'(1);
                        if (step_y)
                            cur_y_reg <= sy_neg_reg ? cur_y_reg - VPOS_WIDTH'(1)
                                                    : cur_y_reg + VPOS_WIDTH'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign writecounter_x = cur_x_reg;
    assign writecounter_y = cur_y_reg;
    assign writergb       = color_reg;
    assign busy           = (state_reg == S_SETUP) || (state_reg == S_PLOT);
    assign done           = (state_reg == S_DONE);

endmodule

// File: tb/tb_line_rasterizer.sv
// tb_line_rasterizer: directed checks of the Bresenham line engine.
// Honours LINE_RASTERIZER_CLIP_EN for the clipping case.
module tb_line_rasterizer;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic [9:0] x0 = '0, x1 = '0;
    logic [9:0] y0 = '0, y1 = '0;
    logic [2:0] color = '0;
    logic       fifofull = 1'b0;
    logic       fifopush;
    logic [9:0] writecounter_x, writecounter_y;
    logic [2:0] writergb;
    logic       busy, done;

    int errors = 0;
    int checks = 0;

    // Push log filled by the monitor below
    int px [0:255];
    int py [0:255];
    int pc [0:255];
    int n_push = 0;
    int n_done = 0;
    int cyc = 0;

    line_rasterizer dut (
        .clk(clk), .reset(reset), .start(start),
        .x0(x0), .y0(y0), .x1(x1), .y1(y1), .color(color),
        .fifofull(fifofull), .fifopush(fifopush),
        .writecounter_x(writecounter_x), .writecounter_y(writecounter_y),
        .writergb(writergb), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    // Cycle index: value after the posedge that opens the current period
    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: record every push and done pulse mid-cycle
    always @(negedge clk) begin
        if (fifopush && n_push < 256) begin
            px[n_push] <= int'(writecounter_x);
            py[n_push] <= int'(writecounter_y);
            pc[n_push] <= cyc;
            n_push     <= n_push + 1;
        end
        if (done) n_done <= n_done + 1;
    end

    task automatic check(input string tag, input int obs, input int expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    // Issue a one-cycle start; returns the index of the accepting edge
    task automatic issue(input int ax0, input int ay0, input int ax1, input int ay1,
                         input int c, output int acc);
        x0 = 10'(ax0); y0 = 10'(ay0); x1 = 10'(ax1); y1 = 10'(ay1); color = 3'(c);
        start = 1'b1;
        acc = cyc + 1;
        tick();
        start = 1'b0;
    endtask

    // Wait for done within a cycle budget; returns its cycle index
    task automatic wait_done(input string tag, input int budget, output int dcyc);
        dcyc = -1;
        for (int i = 0; i < budget; i++) begin
            if (done) begin
                dcyc = cyc;
                break;
            end
            tick();
        end
        if (dcyc < 0) check({tag, "_timeout"}, 0, 1);
    endtask

    initial begin
        int acc, dcyc, base, dbase, t0;
        int ex [0:7];
        int ey [0:7];

        // ---------------- reset state ----------------
        repeat (3) tick();
        reset = 1'b0;
        tick();
        check("rst_push", int'(fifopush), 0);
        check("rst_x", int'(writecounter_x), 0);
        check("rst_y", int'(writecounter_y), 0);
        check("rst_rgb", int'(writergb), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);

        // ---------------- horizontal line (10,5)->(14,5) ----------------
        base = n_push;
        issue(10, 5, 14, 5, 4, acc);
        check("h_busy", int'(busy), 1);
        wait_done("h", 40, dcyc);
        tick();
        check("h_count", n_push - base, 5);
        for (int i = 0; i < 5; i++) begin
            check($sformatf("h_x%0d", i), px[base+i], 10 + i);
            check($sformatf("h_y%0d", i), py[base+i], 5);
            check($sformatf("h_c%0d", i), pc[base+i], acc + 1 + i);
        end
        check("h_done_cyc", dcyc, acc + 6);
        check("h_rgb", int'(writergb), 4);
        check("h_busy_after", int'(busy), 0);

        // ---------------- steep reverse diagonal (20,20)->(17,13) ----------------
        ex = '{20, 20, 19, 19, 18, 18, 17, 17};
        ey = '{20, 19, 18, 17, 16, 15, 14, 13};
        base = n_push;
        issue(20, 20, 17, 13, 2, acc);
        wait_done("d", 40, dcyc);
        tick();
        check("d_count", n_push - base, 8);
        for (int i = 0; i < 8; i++) begin
            check($sformatf("d_x%0d", i), px[base+i], ex[i]);
            check($sformatf("d_y%0d", i), py[base+i], ey[i]);
        end
        check("d_done_cyc", dcyc, acc + 9);

        // ---------------- backpressure (0,0)->(7,0) ----------------
        base = n_push;
        issue(0, 0, 7, 0, 1, acc);
        for (int i = 0; i < 20 && (n_push - base) < 2; i++) tick();
        check("bp_two", n_push - base, 2);
        @(posedge clk);
        #1;
        fifofull = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("bp_stall_push%0d", i), int'(fifopush), 0);
            check($sformatf("bp_stall_x%0d", i), int'(writecounter_x), 2);
            @(posedge clk);
            #1;
        end
        fifofull = 1'b0;
        wait_done("bp", 40, dcyc);
        tick();
        check("bp_count", n_push - base, 8);
        for (int i = 0; i < 8; i++)
            check($sformatf("bp_x%0d", i), px[base+i], i);
        check("bp_last_cyc", pc[base+7], acc + 1 + 7 + 3);
        check("bp_done_cyc", dcyc, acc + 12);

        // ---------------- degenerate line + ignored start ----------------
        base = n_push;
        dbase = n_done;
        issue(5, 5, 5, 5, 7, acc);
        x0 = 10'd0; y0 = 10'd0; x1 = 10'd9; y1 = 10'd0;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (8) tick();
        check("dg_count", n_push - base, 1);
        check("dg_x", px[base], 5);
        check("dg_y", py[base], 5);
        check("dg_done_pulses", n_done - dbase, 1);
        check("dg_busy", int'(busy), 0);

        // ---------------- reset mid-line (0,0)->(99,0) ----------------
        base = n_push;
        issue(0, 0, 99, 0, 6, acc);
        for (int i = 0; i < 20 && (n_push - base) < 3; i++) tick();
        check("mr_three", n_push - base, 3);
        reset = 1'b1;
        tick();
        check("mr_push", int'(fifopush), 0);
        check("mr_busy", int'(busy), 0);
        check("mr_x", int'(writecounter_x), 0);
        check("mr_y", int'(writecounter_y), 0);
        check("mr_rgb", int'(writergb), 0);
        check("mr_done", int'(done), 0);
        reset = 1'b0;
        t0 = n_push;
        repeat (4) tick();
        check("mr_quiet", n_push - t0, 0);
        base = n_push;
        issue(3, 4, 5, 6, 5, acc);
        wait_done("mr2", 40, dcyc);
        tick();
        check("mr2_count", n_push - base, 3);
        for (int i = 0; i < 3; i++) begin
            check($sformatf("mr2_x%0d", i), px[base+i], 3 + i);
            check($sformatf("mr2_y%0d", i), py[base+i], 4 + i);
        end
        check("mr2_rgb", int'(writergb), 5);

        // ---------------- right-edge line (636,0)->(643,0) ----------------
        base = n_push;
        issue(636, 0, 643, 0, 3, acc);
        wait_done("cl", 40, dcyc);
        tick();
`ifdef LINE_RASTERIZER_CLIP_EN
        check("cl_count", n_push - base, 4);
        for (int i = 0; i < 4; i++)
            check($sformatf("cl_x%0d", i), px[base+i], 636 + i);
`else
        check("cl_count", n_push - base, 8);
        for (int i = 0; i < 8; i++)
            check($sformatf("cl_x%0d", i), px[base+i], 636 + i);
`endif
        check("cl_done_cyc", dcyc, acc + 1 + 8);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
